dyn_bus_sizer: RTL and testbench
================================

Name: dyn_bus_sizer

Overview:
- Parametrised dynamic bus sizing engine between the MC68040 local bus (TS/TA/TEA, SIZ, A[1:0]) and the AmigaPCI port bus (DSACK-terminated, 68030-style).
- Splits each CPU transfer (byte, word, long, line) into port sub-cycles sized by the DSACK response: 32-, 16- or 8-bit ports, including byte ports.
- Routes byte lanes and assembles read data; terminates each CPU longword with TA and adds bus-error abort.
- Sits on the CPU card between the CPU data buffers and the AmigaPCI bus; tri-state control stays at top level.

Parameters:
- LINE_LONGS, 4, longwords per line (burst) transfer; power of two, 1..8.
- TO_CYCLES, 255, watchdog limit in BCLK cycles (used only with BUS_TIMEOUT_EN).

Ports:
- BCLK  in  1  bus clock; all logic on the rising edge.
- nRESET  in  1  asynchronous active-low reset.
- nTS_CPU  in  1  CPU transfer start, active low.
- A_CPU  in  2+log2(LINE_LONGS)  CPU address low bits.
- SIZ_CPU  in  2  CPU size: 00 long, 01 byte, 10 word, 11 line.
- RnW  in  1  1 = read.
- D_CPU_W  in  32  CPU write data; byte0 = [31:24], MSB.
- D_CPU_R  out  32  assembled read data to the CPU.
- nTA_CPU  out  1  transfer acknowledge to the CPU, active low.
- nTEA_CPU  out  1  transfer error acknowledge to the CPU, active low.
- nTS_BUS  out  1  sub-cycle start to the port bus.
- A_BUS  out  2+log2(LINE_LONGS)  sub-cycle address.
- SIZ_BUS  out  2  bytes remaining in the current longword: 00=4, 01=1, 10=2, 11=3.
- D_BUS_W  out  32  lane-routed write data.
- D_BUS_R  in  32  port read data.
- DSACK  in  2  {DSACK1,DSACK0}, active low: 00 32-bit, 01 16-bit, 10 8-bit, 11 wait.
- nBERR  in  1  bus error, active low.

Behaviour:
- Reset values: nTA_CPU=1, nTEA_CPU=1, nTS_BUS=1, A_BUS=0, SIZ_BUS=0, D_BUS_W=0, D_CPU_R=0, state IDLE. Reset mid-cycle aborts immediately; no TA is issued.
- States:
  - IDLE: nTS_CPU sampled low → latch A_CPU, SIZ_CPU, RnW; set rem bytes (1/2/4, or 4 for each line long) and long_cnt=LINE_LONGS-1 for a line or 0 otherwise → START.
  - START: nTS_BUS low for exactly one BCLK; A_BUS=base+offset, SIZ_BUS=rem → WAIT.
  - WAIT: sample DSACK every BCLK. 11 = stay. Otherwise width w = min(rem, 4 − offset[1:0] for a 32-bit port; 2 − offset[0] for a 16-bit port; 1 for an 8-bit port); offset += w; rem −= w. rem=0 → ACK, else → START.
  - ACK: nTA_CPU low one BCLK. long_cnt>0 → decrement, offset wraps within the line (wrap-around burst), rem=4 → START; else → IDLE.
- nBERR sampled low in WAIT → ERR: nTEA_CPU low one BCLK → IDLE, remaining sub-cycles discarded. nBERR beats DSACK on the same edge.
- Word with A_CPU[0]=1 is illegal: go directly to ERR; no bus cycle is run.
- Write routing: 32-bit port gets D_CPU_W unchanged. 16-bit port gets the addressed halfword on [31:16], replicated on [15:0]. 8-bit port gets the addressed byte on all four lanes.
  - The first sub-cycle presents the 32-bit routing, replicating the upper halfword onto the lower lanes for A[0]=0 and the addressed byte onto the lower lanes for byte accesses, so it is valid for any responding port size.
- Read assembly: port bytes are written into D_CPU_R lanes by offset (16-bit port from [31:16], 8-bit port from [31:24]). D_CPU_R is stable when nTA_CPU is low and holds until the next TS.
- Latency: TS to nTS_BUS is 1 BCLK; DSACK sample to nTA_CPU is 1 BCLK.

Optional Feature:
- BUS_TIMEOUT_EN defined: counter clears in START and increments in WAIT. Reaching TO_CYCLES → ERR (nTEA_CPU pulse).
- Undefined: WAIT holds indefinitely; no counter logic.

Decomposition:
- Package dyn_bus_pkg: state enum, SIZ encodings, DSACK port-width decode constants, lane-select function.
- One sub-module, dbs_lane_router: combinational write steering and read-merge enables from offset and port width.

Test Plan:
- Long read, A=0, DSACK=00 after 2 waits, D_BUS_R=32'h11223344 → one nTS_BUS; D_CPU_R=32'h11223344 with one nTA_CPU pulse.
- Long write 32'hAABBCCDD to a 16-bit port → two sub-cycles, A_BUS 0 then 2, SIZ_BUS 00 then 10, D_BUS_W[31:16]=AABB then CCDD, one nTA_CPU.
- Byte read A=3 from an 8-bit port, D_BUS_R[31:24]=8'h5A → SIZ_BUS=01, D_CPU_R[7:0]=8'h5A.
- Line read, A=4'h8, 8-bit port → 16 sub-cycles, A_BUS wraps 8..F, 0..7; four nTA_CPU pulses.
- nBERR low together with DSACK=00 in the second sub-cycle of a 16-bit long write → nTEA_CPU pulse, no nTA_CPU, return to IDLE.
- With BUS_TIMEOUT_EN, TO_CYCLES=8 and DSACK held 11 → nTEA_CPU low exactly 8 BCLK after WAIT entry.

Source files
------------

// File: rtl/dyn_bus_pkg.sv
// Shared types and helpers for the MC68040-to-port-bus dynamic bus sizer.
// Holds the FSM states, SIZ/DSACK encodings and the write lane steering function.
package dyn_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_ACK,
    ST_ERR
  } state_t;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam logic [1:0] DS_32   = 2'b00;
  localparam logic [1:0] DS_16   = 2'b01;
  localparam logic [1:0] DS_8    = 2'b10;
  localparam logic [1:0] DS_WAIT = 2'b11;

  // Replicate the addressed halfword/byte so a narrow port finds it on its own lanes.
  function automatic logic [31:0] lane_select(input logic [31:0] data,
                                              input logic [1:0]  off,
                                              input logic [1:0]  port);
    logic [15:0] hw;
    logic [7:0]  b;
    hw = off[1] ? data[15:0] : data[31:16];
    case (off)
      2'd0:    b = data[31:24];
      2'd1:    b = data[23:16];
      2'd2:    b = data[15:8];
      default: b = data[7:0];
    endcase
    case (port)
      DS_32:   lane_select = data;
      DS_16:   lane_select = {hw, hw};
      default: lane_select = {4{b}};
    endcase
  endfunction

endpackage

// File: rtl/dyn_bus_sizer_lane_router.sv
// Combinational lane steering for the bus sizer: write routing, read alignment,
// per-lane merge enables and the byte count moved by one port sub-cycle.
module dbs_lane_router
  import dyn_bus_pkg::*;
(
  input  logic [31:0] wr_data,
  input  logic [1:0]  wr_off,
  input  logic [1:0]  wr_port,
  input  logic [31:0] rd_data,
  input  logic [1:0]  rd_off,
  input  logic [1:0]  rd_port,
  input  logic [2:0]  rem,
  output logic [31:0] wr_lanes,
  output logic [31:0] rd_lanes,
  output logic [3:0]  rd_en,
  output logic [2:0]  width
);

  logic [2:0] limit;
  logic [2:0] stop;

  assign wr_lanes = lane_select(wr_data, wr_off, wr_port);

  // A port can only move bytes up to its own alignment boundary.
  always_comb begin
    limit = 3'd1;
    case (rd_port)
      DS_32:   limit = 3'd4 - {1'b0, rd_off};
      DS_16:   limit = 3'd2 - {2'b00, rd_off[0]};
      default: limit = 3'd1;
    endcase
    width = (rem < limit) ? rem : limit;
    stop  = {1'b0, rd_off} + width;
    rd_en = '0;
    for (int i = 0; i < 4; i++) begin
      rd_en[i] = (3'(i) >= {1'b0, rd_off}) && (3'(i) < stop);
    end
  end

  always_comb begin
    rd_lanes = rd_data;
    case (rd_port)
      DS_32:   rd_lanes = rd_data;
      DS_16:   rd_lanes = {2{rd_data[31:16]}};
      default: rd_lanes = {4{rd_data[31:24]}};
    endcase
  end

endmodule

// File: rtl/dyn_bus_sizer.sv
// Dynamic bus sizer: splits 68040 transfers into DSACK-sized port sub-cycles.
// Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module dyn_bus_sizer
  import dyn_bus_pkg::*;
#(
  parameter int LINE_LONGS = 4,
  parameter int TO_CYCLES  = 255
) (
  input  logic                             BCLK,
  input  logic                             nRESET,
  input  logic                             nTS_CPU,
  input  logic [$clog2(LINE_LONGS)+1:0]    A_CPU,
  input  logic [1:0]                       SIZ_CPU,
  input  logic                             RnW,
  input  logic [31:0]                      D_CPU_W,
  output logic [31:0]                      D_CPU_R,
  output logic                             nTA_CPU,
  output logic                             nTEA_CPU,
  output logic                             nTS_BUS,
  output logic [$clog2(LINE_LONGS)+1:0]    A_BUS,
  output logic [1:0]                       SIZ_BUS,
  output logic [31:0]                      D_BUS_W,
  input  logic [31:0]                      D_BUS_R,
  input  logic [1:0]                       DSACK,
  input  logic                             nBERR
);

  localparam int AW = 2 + $clog2(LINE_LONGS);
  localparam int LW = (LINE_LONGS > 1) ? $clog2(LINE_LONGS) : 1;

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [2:0]    rem, rem_n;
  logic [LW-1:0] long_cnt, cnt_n;
  logic          rnw, rnw_n;
  logic          first, first_n;
  logic [1:0]    port_q, port_n;
  logic [1:0]    wr_port;
  logic [31:0]   wr_lanes, rd_lanes;
  logic [3:0]    rd_en;
  logic [2:0]    width;
  logic          merge;
  logic          timeout;

  dbs_lane_router u_router (
    .wr_data  (D_CPU_W),
    .wr_off   (addr_n[1:0]),
    .wr_port  (wr_port),
    .rd_data  (D_BUS_R),
    .rd_off   (addr[1:0]),
    .rd_port  (DSACK),
    .rem      (rem),
    .wr_lanes (wr_lanes),
    .rd_lanes (rd_lanes),
    .rd_en    (rd_en),
    .width    (width)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge BCLK or negedge nRESET) begin
    if (!nRESET)                to_cnt <= '0;
    else if (state == ST_START) to_cnt <= '0;
    else if (state == ST_WAIT)  to_cnt <= to_cnt + TW'(1);
  end

  assign timeout = (to_cnt == TW'(TO_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    addr_n  = addr;
    rem_n   = rem;
    cnt_n   = long_cnt;
    rnw_n   = rnw;
    first_n = first;
    port_n  = port_q;
    merge   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!nTS_CPU) begin
          addr_n  = A_CPU;
          rnw_n   = RnW;
          first_n = 1'b1;
          case (SIZ_CPU)
            SIZ_BYTE: rem_n = 3'd1;
            SIZ_WORD: rem_n = 3'd2;
            default:  rem_n = 3'd4;
          endcase
          cnt_n   = (SIZ_CPU == SIZ_LINE) ? LW'(LINE_LONGS - 1) : '0;
          state_n = (SIZ_CPU == SIZ_WORD && A_CPU[0]) ? ST_ERR : ST_START;
        end
      end
      ST_START: state_n = ST_WAIT;
      ST_WAIT: begin
        // Bus error wins over any DSACK seen on the same edge.
        if (!nBERR) begin
          state_n = ST_ERR;
        end else if (DSACK != DS_WAIT) begin
          merge   = rnw;
          addr_n  = addr + AW'(width);
          rem_n   = rem - width;
          first_n = 1'b0;
          port_n  = DSACK;
          state_n = (rem == width) ? ST_ACK : ST_START;
        end else if (timeout) begin
          state_n = ST_ERR;
        end
      end
      ST_ACK: begin
        if (long_cnt != '0) begin
          cnt_n   = long_cnt - LW'(1);
          rem_n   = 3'd4;
          first_n = 1'b1;
          state_n = ST_START;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ERR:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // First sub-cycle of a longword must suit any port; later ones follow the known port.
    wr_port = port_n;
    if (first_n) begin
      case (rem_n)
        3'd1:    wr_port = DS_8;
        3'd4:    wr_port = DS_32;
        default: wr_port = DS_16;
      endcase
    end
  end

  always_ff @(posedge BCLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      addr     <= '0;
      rem      <= '0;
      long_cnt <= '0;
      rnw      <= 1'b1;
      first    <= 1'b0;
      port_q   <= DS_32;
      nTS_BUS  <= 1'b1;
      nTA_CPU  <= 1'b1;
      nTEA_CPU <= 1'b1;
      A_BUS    <= '0;
      SIZ_BUS  <= '0;
      D_BUS_W  <= '0;
      D_CPU_R  <= '0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      rem      <= rem_n;
      long_cnt <= cnt_n;
      rnw      <= rnw_n;
      first    <= first_n;
      port_q   <= port_n;
      nTS_BUS  <= (state_n != ST_START);
      nTA_CPU  <= (state_n != ST_ACK);
      nTEA_CPU <= (state_n != ST_ERR);
      if (state_n == ST_START) begin
        A_BUS   <= addr_n;
        SIZ_BUS <= rem_n[1:0];
      end
      if (state_n == ST_START || state_n == ST_WAIT) D_BUS_W <= wr_lanes;
      if (merge) begin
        for (int i = 0; i < 4; i++) begin
          if (rd_en[i]) D_CPU_R[31-8*i -: 8] <= rd_lanes[31-8*i -: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dyn_bus_sizer.sv
// Scoreboard bench for dyn_bus_sizer: directed CPU transfers against a model port.
// Define BUS_TIMEOUT_EN to also exercise the watchdog.
module tb_dyn_bus_sizer;
  import dyn_bus_pkg::*;

  logic        BCLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        nTS_CPU = 1'b1;
  logic [3:0]  A_CPU = '0;
  logic [1:0]  SIZ_CPU = '0;
  logic        RnW = 1'b1;
  logic [31:0] D_CPU_W = '0;
  logic [31:0] D_CPU_R;
  logic        nTA_CPU, nTEA_CPU, nTS_BUS;
  logic [3:0]  A_BUS;
  logic [1:0]  SIZ_BUS;
  logic [31:0] D_BUS_W;
  logic [31:0] D_BUS_R = '0;
  logic [1:0]  DSACK = 2'b11;
  logic        nBERR = 1'b1;

  dyn_bus_sizer #(.LINE_LONGS(4), .TO_CYCLES(8)) dut (
    .BCLK(BCLK), .nRESET(nRESET), .nTS_CPU(nTS_CPU), .A_CPU(A_CPU), .SIZ_CPU(SIZ_CPU),
    .RnW(RnW), .D_CPU_W(D_CPU_W), .D_CPU_R(D_CPU_R), .nTA_CPU(nTA_CPU), .nTEA_CPU(nTEA_CPU),
    .nTS_BUS(nTS_BUS), .A_BUS(A_BUS), .SIZ_BUS(SIZ_BUS), .D_BUS_W(D_BUS_W), .D_BUS_R(D_BUS_R),
    .DSACK(DSACK), .nBERR(nBERR)
  );

  always #5 BCLK = ~BCLK;

  typedef enum int {K_SUB = 0, K_TA = 1, K_TEA = 2} kind_t;
  typedef struct {
    kind_t       kind;
    logic [3:0]  addr;
    logic [1:0]  siz;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          sub_cyc = 0;
  int          tea_cyc = 0;
  string       cur_test = "reset";
  logic [7:0]  mem [16];
  logic [1:0]  resp_port = 2'b00;
  int          resp_waits = 0;
  int          resp_berr_sub = -1;
  int          resp_sub = 0;
  logic [3:0]  resp_addr;

  always @(posedge BCLK) cyc++;

  function automatic logic [31:0] portData(input logic [3:0] a, input logic [1:0] p);
    int b;
    case (p)
      DS_32: begin
        b = int'({a[3:2], 2'b00});
        portData = {mem[b], mem[b+1], mem[b+2], mem[b+3]};
      end
      DS_16: begin
        b = int'({a[3:1], 1'b0});
        portData = {mem[b], mem[b+1], 16'hEEEE};
      end
      default: portData = {mem[int'(a)], 24'hEEEEEE};
    endcase
  endfunction

  // Model port: answer each sub-cycle after resp_waits wait states.
  always begin
    @(negedge BCLK);
    while (!nTS_BUS && nRESET) begin
      resp_addr = A_BUS;
      @(negedge BCLK);
      repeat (resp_waits) @(negedge BCLK);
      D_BUS_R = portData(resp_addr, resp_port);
      if (resp_sub == resp_berr_sub) begin
        nBERR = 1'b0;
        DSACK = DS_32;
      end else begin
        DSACK = resp_port;
      end
      resp_sub++;
      @(negedge BCLK);
      DSACK = DS_WAIT;
      nBERR = 1'b1;
    end
  end

  task automatic checkOutput(input kind_t kind);
    exp_t        e;
    logic [31:0] got;
    tests++;
    got = (kind == K_SUB) ? D_BUS_W : ((kind == K_TA) ? D_CPU_R : 32'h0);
    if (sbq.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s_unexpected: got event kind=%0d a=%h data=%h, required no event",
               cur_test, kind, A_BUS, got);
      return;
    end
    e = sbq.pop_front();
    if (e.kind != kind || (kind == K_SUB && (A_BUS !== e.addr || SIZ_BUS !== e.siz)) ||
        ((got & e.mask) !== (e.data & e.mask))) begin
      fails++;
      $display("[TB] FAIL %s: got kind=%0d a=%h siz=%b data=%h, required kind=%0d a=%h siz=%b data=%h (mask %h)",
               cur_test, kind, A_BUS, SIZ_BUS, got, e.kind, e.addr, e.siz, e.data, e.mask);
    end
  endtask

  always @(negedge BCLK) begin
    if (nRESET) begin
      if (!nTS_BUS) begin
        sub_cyc = cyc;
        checkOutput(K_SUB);
      end
      if (!nTA_CPU) checkOutput(K_TA);
      if (!nTEA_CPU) begin
        tea_cyc = cyc;
        checkOutput(K_TEA);
      end
    end
  end

  task automatic checkSignal(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic pushSub(input logic [3:0] a, input logic [1:0] s, input logic [31:0] d, input logic [31:0] m);
    exp_t e;
    e.kind = K_SUB; e.addr = a; e.siz = s; e.data = d; e.mask = m;
    sbq.push_back(e);
  endtask

  task automatic pushAck(input kind_t k, input logic [31:0] d, input logic [31:0] m);
    exp_t e;
    e.kind = k; e.addr = '0; e.siz = '0; e.data = d; e.mask = m;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] a, input logic [1:0] siz,
                               input logic rnw, input logic [31:0] d, input logic [1:0] port,
                               input int waits, input int berr_sub);
    cur_test      = name;
    resp_port     = port;
    resp_waits    = waits;
    resp_berr_sub = berr_sub;
    resp_sub      = 0;
    @(negedge BCLK);
    A_CPU = a; SIZ_CPU = siz; RnW = rnw; D_CPU_W = d; nTS_CPU = 1'b0;
    @(negedge BCLK);
    nTS_CPU = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (sbq.size() == 0) break;
      @(negedge BCLK);
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_budget: got %0d events still pending, required 0", name, sbq.size());
      sbq.delete();
    end
    repeat (4) @(negedge BCLK);
  endtask

  initial begin
    logic [1:0]  siz_tab [4];
    logic [31:0] line_tab [4];
    siz_tab  = '{2'b00, 2'b11, 2'b10, 2'b01};
    line_tab = '{32'hA8A9AAAB, 32'hACADAEAF, 32'h1122335A, 32'hA4A5A6A7};
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    repeat (3) @(negedge BCLK);
    checkSignal("rst_nTA", {31'h0, nTA_CPU}, 32'h1);
    checkSignal("rst_nTEA", {31'h0, nTEA_CPU}, 32'h1);
    checkSignal("rst_nTS_BUS", {31'h0, nTS_BUS}, 32'h1);
    checkSignal("rst_A_BUS", {28'h0, A_BUS}, 32'h0);
    checkSignal("rst_SIZ_BUS", {30'h0, SIZ_BUS}, 32'h0);
    checkSignal("rst_D_BUS_W", D_BUS_W, 32'h0);
    checkSignal("rst_D_CPU_R", D_CPU_R, 32'h0);
    nRESET = 1'b1;
    repeat (2) @(negedge BCLK);

    pushSub(4'h0, 2'b00, 32'h0, 32'h0);
    pushAck(K_TA, 32'h11223344, 32'hFFFFFFFF);
    applyStimulus("long_rd_32", 4'h0, SIZ_LONG, 1'b1, 32'h0, DS_32, 2, -1);

    pushSub(4'h0, 2'b00, 32'hAABB0000, 32'hFFFF0000);
    pushSub(4'h2, 2'b10, 32'hCCDD0000, 32'hFFFF0000);
    pushAck(K_TA, 32'h0, 32'h0);
    applyStimulus("long_wr_16", 4'h0, SIZ_LONG, 1'b0, 32'hAABBCCDD, DS_16, 0, -1);

    pushSub(4'h0, 2'b00, 32'h12345678, 32'hFFFFFFFF);
    pushAck(K_TA, 32'h0, 32'h0);
    applyStimulus("long_wr_32", 4'h0, SIZ_LONG, 1'b0, 32'h12345678, DS_32, 1, -1);

    mem[3] = 8'h5A;
    pushSub(4'h3, 2'b01, 32'h0, 32'h0);
    pushAck(K_TA, 32'h0000005A, 32'h000000FF);
    applyStimulus("byte_rd_8", 4'h3, SIZ_BYTE, 1'b1, 32'h0, DS_8, 0, -1);

    for (int k = 0; k < 16; k++) begin
      pushSub(4'(8 + k), siz_tab[k % 4], 32'h0, 32'h0);
      if (k % 4 == 3) pushAck(K_TA, line_tab[k / 4], 32'hFFFFFFFF);
    end
    applyStimulus("line_rd_8", 4'h8, SIZ_LINE, 1'b1, 32'h0, DS_8, 0, -1);

    pushSub(4'h0, 2'b00, 32'hAABB0000, 32'hFFFF0000);
    pushSub(4'h2, 2'b10, 32'hCCDD0000, 32'hFFFF0000);
    pushAck(K_TEA, 32'h0, 32'h0);
    applyStimulus("berr_wr_16", 4'h0, SIZ_LONG, 1'b0, 32'hAABBCCDD, DS_16, 0, 1);

    pushAck(K_TEA, 32'h0, 32'h0);
    applyStimulus("word_odd", 4'h1, SIZ_WORD, 1'b1, 32'h0, DS_16, 0, -1);

    pushSub(4'h2, 2'b10, 32'h0, 32'h0);
    pushAck(K_TA, 32'h0000335A, 32'h0000FFFF);
    applyStimulus("word_rd_16", 4'h2, SIZ_WORD, 1'b1, 32'h0, DS_16, 1, -1);

    pushSub(4'h1, 2'b01, 32'h5C5C5C5C, 32'hFFFFFFFF);
    pushAck(K_TA, 32'h0, 32'h0);
    applyStimulus("byte_wr_8", 4'h1, SIZ_BYTE, 1'b0, 32'h115C2233, DS_8, 0, -1);

    pushSub(4'h2, 2'b10, 32'h0000BEEF, 32'h0000FFFF);
    pushAck(K_TA, 32'h0, 32'h0);
    applyStimulus("word_wr_32", 4'h2, SIZ_WORD, 1'b0, 32'h0000BEEF, DS_32, 0, -1);

    pushSub(4'h0, 2'b00, 32'h01000000, 32'hFF000000);
    pushSub(4'h1, 2'b11, 32'h02020202, 32'hFFFFFFFF);
    pushSub(4'h2, 2'b10, 32'h03030303, 32'hFFFFFFFF);
    pushSub(4'h3, 2'b01, 32'h04040404, 32'hFFFFFFFF);
    pushAck(K_TA, 32'h0, 32'h0);
    applyStimulus("long_wr_8", 4'h0, SIZ_LONG, 1'b0, 32'h01020304, DS_8, 0, -1);

    pushSub(4'h4, 2'b00, 32'h0, 32'h0);
    pushSub(4'h6, 2'b10, 32'h0, 32'h0);
    pushAck(K_TA, 32'hA4A5A6A7, 32'hFFFFFFFF);
    applyStimulus("long_rd_16", 4'h4, SIZ_LONG, 1'b1, 32'h0, DS_16, 0, -1);

`ifdef BUS_TIMEOUT_EN
    pushSub(4'h0, 2'b00, 32'h0, 32'h0);
    pushAck(K_TEA, 32'h0, 32'h0);
    applyStimulus("timeout", 4'h0, SIZ_LONG, 1'b1, 32'h0, DS_32, 30, -1);
    repeat (30) @(negedge BCLK);
    checkSignal("timeout_delay", 32'(tea_cyc - sub_cyc), 32'd9);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_watchdog: got no finish, required finish within limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
